// File: rtl/gnr_cycle_detector.sv
// Cycle detector for a node network, using Floyd's slow/fast copies. It first
// finds where the two copies meet, then steps only the fast copy to measure the period.
module gnr_cycle_detector #(
    parameter int N_NODES   = 8,
    parameter int CNT_W     = 16,
    parameter int MAX_PAIRS = 1000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [N_NODES-1:0] init_state,
    input  logic [N_NODES-1:0] s0_vec,
    input  logic [N_NODES-1:0] s1_vec,
    output logic               reset_nos,
    output logic [N_NODES-1:0] init_vec,
    output logic               start_s0,
    output logic               start_s1,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [CNT_W-1:0]   meet_steps,
    output logic [CNT_W-1:0]   period,
    output logic [N_NODES-1:0] attractor,
    output logic               timeout
);

    typedef enum logic [3:0] {
        IDLE, LOAD, SETTLE, RUN_A, RUN_B, CHECK, P_STEP, P_CHECK, DONE
    } state_t;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PAIRS);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] pair_cnt, per_cnt;
    logic             meet_hit, loop_hit;

    assign meet_hit = (s0_vec == s1_vec);
    assign loop_hit = (s1_vec == attractor);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // The node controls are decoded from the state register only, so no input reaches them directly.
    always_comb begin
        state_nxt = state;
        reset_nos = 1'b0;
        start_s0  = 1'b0;
        start_s1  = 1'b0;
        busy      = (state != IDLE);
        out_valid = (state == DONE);
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    begin reset_nos = 1'b1; state_nxt = SETTLE; end
            SETTLE:  state_nxt = RUN_A;
            RUN_A:   begin start_s0 = 1'b1; start_s1 = 1'b1; state_nxt = RUN_B; end
            RUN_B:   begin start_s0 = 1'b1; start_s1 = 1'b1; state_nxt = CHECK; end
            CHECK: begin
                if (meet_hit)                  state_nxt = P_STEP;
                else if (pair_cnt == MAX_CNT)  state_nxt = DONE;
                else                           state_nxt = RUN_A;
            end
            P_STEP:  begin start_s1 = 1'b1; state_nxt = P_CHECK; end
            P_CHECK: begin
                if (loop_hit || per_cnt == MAX_CNT) state_nxt = DONE;
                else                                state_nxt = P_STEP;
            end
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The MAX_CNT checks stop both counters before they can wrap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_vec   <= '0;
            pair_cnt   <= '0;
            per_cnt    <= '0;
            meet_steps <= '0;
            period     <= '0;
            attractor  <= '0;
            timeout    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    init_vec   <= init_state;
                    pair_cnt   <= '0;
                    per_cnt    <= '0;
                    meet_steps <= '0;
                    period     <= '0;
                    attractor  <= '0;
                    timeout    <= 1'b0;
                end
                RUN_B:  pair_cnt <= pair_cnt + 1'b1;
                CHECK: begin
                    if (meet_hit) begin
                        meet_steps <= pair_cnt;
                        attractor  <= s0_vec;
                    end else if (pair_cnt == MAX_CNT) begin
                        meet_steps <= pair_cnt;
                        attractor  <= '0;
                        timeout    <= 1'b1;
                    end
                end
                P_STEP: per_cnt <= per_cnt + 1'b1;
                P_CHECK: begin
                    if (loop_hit) begin
                        period <= per_cnt;
                    end else if (per_cnt == MAX_CNT) begin
                        period  <= '0;
                        timeout <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gnr_cycle_detector.sv
// Directed bench for gnr_cycle_detector. Each DUT is driven by a small node-network model:
// hold, toggle, or a mod-4 counter in the low bits.
module tb_gnr_cycle_detector;
    localparam int N = 4;
    localparam int CW = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          a_start = 0, a_ready = 0;
    logic [N-1:0]  a_init = '0, a_s0 = '0, a_s1 = '0;
    logic [1:0]    a_mode = 0;
    logic          a_ph = 0;
    logic          a_reset_nos, a_start_s0, a_start_s1, a_busy, a_out_valid, a_timeout;
    logic [N-1:0]  a_init_vec, a_attr;
    logic [CW-1:0] a_meet, a_period;

    logic          b_start = 0, b_ready = 0;
    logic [N-1:0]  b_s0 = '0, b_s1 = '0;
    logic          b_ph = 0;
    logic          b_reset_nos, b_start_s0, b_start_s1, b_busy, b_out_valid, b_timeout;
    logic [N-1:0]  b_init_vec, b_attr;
    logic [CW-1:0] b_meet, b_period;

    int cnt_s0 = 0, cnt_s1 = 0, cnt_rn = 0;

    gnr_cycle_detector #(.N_NODES(N), .CNT_W(CW), .MAX_PAIRS(1000)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(a_start), .init_state(a_init),
        .s0_vec(a_s0), .s1_vec(a_s1), .reset_nos(a_reset_nos), .init_vec(a_init_vec),
        .start_s0(a_start_s0), .start_s1(a_start_s1), .busy(a_busy),
        .out_valid(a_out_valid), .out_ready(a_ready), .meet_steps(a_meet),
        .period(a_period), .attractor(a_attr), .timeout(a_timeout));

    gnr_cycle_detector #(.N_NODES(N), .CNT_W(CW), .MAX_PAIRS(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(b_start), .init_state(4'b0000),
        .s0_vec(b_s0), .s1_vec(b_s1), .reset_nos(b_reset_nos), .init_vec(b_init_vec),
        .start_s0(b_start_s0), .start_s1(b_start_s1), .busy(b_busy),
        .out_valid(b_out_valid), .out_ready(b_ready), .meet_steps(b_meet),
        .period(b_period), .attractor(b_attr), .timeout(b_timeout));

    function automatic logic [N-1:0] nxt(input logic [1:0] m, input logic [N-1:0] x);
        case (m)
            2'd1:    nxt = ~x;
            2'd2:    nxt = {x[3:2], x[1:0] + 2'd1};
            default: nxt = x;
        endcase
    endfunction

    // Node network: the slow copy advances on the first of each pair of start_s0 pulses.
    always @(posedge clk) begin
        if (a_reset_nos) begin
            a_s0 <= a_init_vec; a_s1 <= a_init_vec; a_ph <= 1'b0;
        end else begin
            if (a_start_s1) a_s1 <= nxt(a_mode, a_s1);
            if (a_start_s0) begin
                if (!a_ph) a_s0 <= nxt(a_mode, a_s0);
                a_ph <= ~a_ph;
            end
        end
        if (b_reset_nos) begin
            b_s0 <= b_init_vec; b_s1 <= b_init_vec; b_ph <= 1'b0;
        end else begin
            if (b_start_s1) b_s1 <= nxt(2'd1, b_s1);
            if (b_start_s0) begin
                if (!b_ph) b_s0 <= nxt(2'd1, b_s0);
                b_ph <= ~b_ph;
            end
        end
        if (a_start_s0)  cnt_s0 <= cnt_s0 + 1;
        if (a_start_s1)  cnt_s1 <= cnt_s1 + 1;
        if (a_reset_nos) cnt_rn <= cnt_rn + 1;
    end

    task automatic start_a(input logic [1:0] m, input logic [N-1:0] iv);
        @(negedge clk);
        a_mode = m; a_init = iv; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
    endtask

    task automatic wait_a(output bit ok);
        int n = 0;
        while (!a_out_valid && n < 300) begin @(negedge clk); n++; end
        ok = a_out_valid;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL wait_a_valid: out_valid=%0b after %0d cycles, required 1", a_out_valid, n);
        end
    endtask

    task automatic release_a;
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL release_a: out_valid=%0b busy=%0b, required 0 0", a_out_valid, a_busy);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({a_busy, a_out_valid, a_reset_nos, a_start_s0, a_start_s1, a_timeout} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy/valid/rn/s0/s1/to=%b, required 000000",
                     {a_busy, a_out_valid, a_reset_nos, a_start_s0, a_start_s1, a_timeout});
        end
        checks++;
        if (a_meet !== 16'd0 || a_period !== 16'd0 || a_attr !== 4'd0 || a_init_vec !== 4'd0) begin
            errors++;
            $display("FAIL reset_data: meet=%0d period=%0d attr=%b init=%b, required 0 0 0000 0000",
                     a_meet, a_period, a_attr, a_init_vec);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy a=%0b b=%0b, required 0 0", a_busy, b_busy);
        end
    endtask

    task automatic test_hold;
        bit ok;
        start_a(2'd0, 4'b1010);
        wait_a(ok);
        checks++;
        if (a_meet !== 16'd1 || a_period !== 16'd1 || a_attr !== 4'b1010 || a_timeout !== 1'b0) begin
            errors++;
            $display("FAIL hold_result: meet=%0d period=%0d attr=%b to=%0b, required 1 1 1010 0",
                     a_meet, a_period, a_attr, a_timeout);
        end
        release_a();
    endtask

    task automatic test_toggle;
        bit ok;
        int s0_0, s1_0, rn_0;
        s0_0 = cnt_s0; s1_0 = cnt_s1; rn_0 = cnt_rn;
        start_a(2'd1, 4'b0000);
        wait_a(ok);
        checks++;
        if (a_meet !== 16'd2 || a_period !== 16'd2 || a_attr !== 4'b0000 || a_timeout !== 1'b0) begin
            errors++;
            $display("FAIL toggle_result: meet=%0d period=%0d attr=%b to=%0b, required 2 2 0000 0",
                     a_meet, a_period, a_attr, a_timeout);
        end
        checks++;
        if (cnt_s0 - s0_0 != 4 || cnt_s1 - s1_0 != 6 || cnt_rn - rn_0 != 1) begin
            errors++;
            $display("FAIL toggle_pulses: s0=%0d s1=%0d rn=%0d, required 4 6 1",
                     cnt_s0 - s0_0, cnt_s1 - s1_0, cnt_rn - rn_0);
        end
        release_a();
    endtask

    task automatic test_timeout;
        int n = 0;
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        while (!b_out_valid && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (b_out_valid !== 1'b1 || b_timeout !== 1'b1 || b_meet !== 16'd1 ||
            b_period !== 16'd0 || b_attr !== 4'b0000) begin
            errors++;
            $display("FAIL timeout_result: valid=%0b to=%0b meet=%0d period=%0d attr=%b, required 1 1 1 0 0000",
                     b_out_valid, b_timeout, b_meet, b_period, b_attr);
        end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        checks++;
        if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_release: valid=%0b busy=%0b, required 0 0", b_out_valid, b_busy);
        end
    endtask

    task automatic test_counter;
        bit ok;
        start_a(2'd2, 4'b0000);
        repeat (4) @(negedge clk);
        a_start = 1'b1; a_init = 4'b0011;
        @(negedge clk);
        a_start = 1'b0;
        wait_a(ok);
        checks++;
        if (a_meet !== 16'd4 || a_period !== 16'd4 || a_attr !== 4'b0000 ||
            a_timeout !== 1'b0 || a_init_vec !== 4'b0000) begin
            errors++;
            $display("FAIL counter_result: meet=%0d period=%0d attr=%b to=%0b init=%b, required 4 4 0000 0 0000",
                     a_meet, a_period, a_attr, a_timeout, a_init_vec);
        end
        // start coinciding with the DONE handshake must not launch a run
        a_start = 1'b1;
        release_a();
        a_start = 1'b0;
        @(negedge clk);
        checks++;
        if (a_busy !== 1'b0 || a_reset_nos !== 1'b0) begin
            errors++;
            $display("FAIL done_start_ignored: busy=%0b reset_nos=%0b, required 0 0", a_busy, a_reset_nos);
        end
    endtask

    task automatic test_back_to_back;
        bit ok;
        bit stable = 1'b1;
        start_a(2'd1, 4'b0000);
        wait_a(ok);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (a_out_valid !== 1'b1 || a_meet !== 16'd2 || a_period !== 16'd2 ||
                a_attr !== 4'b0000 || a_timeout !== 1'b0) stable = 1'b0;
        end
        checks++;
        if (!stable) begin
            errors++;
            $display("FAIL hold_stable: valid=%0b meet=%0d period=%0d attr=%b, required 1 2 2 0000 for 10 cycles",
                     a_out_valid, a_meet, a_period, a_attr);
        end
        release_a();
    endtask

    task automatic test_mid_reset;
        bit ok;
        int n = 0;
        start_a(2'd1, 4'b0000);
        while (!(a_start_s1 && !a_start_s0) && n < 300) begin @(negedge clk); n++; end
        checks++;
        if (!(a_start_s1 && !a_start_s0)) begin
            errors++;
            $display("FAIL reach_p_step: s0=%0b s1=%0b, required 0 1", a_start_s0, a_start_s1);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({a_busy, a_out_valid, a_reset_nos, a_start_s0, a_start_s1, a_timeout} !== 6'b0 ||
            a_meet !== 16'd0 || a_period !== 16'd0 || a_attr !== 4'd0 || a_init_vec !== 4'd0) begin
            errors++;
            $display("FAIL mid_reset: ctrl=%b meet=%0d period=%0d attr=%b init=%b, required all 0",
                     {a_busy, a_out_valid, a_reset_nos, a_start_s0, a_start_s1, a_timeout},
                     a_meet, a_period, a_attr, a_init_vec);
        end
        start_a(2'd0, 4'b0110);
        wait_a(ok);
        checks++;
        if (a_meet !== 16'd1 || a_period !== 16'd1 || a_attr !== 4'b0110 || a_timeout !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_run: meet=%0d period=%0d attr=%b to=%0b, required 1 1 0110 0",
                     a_meet, a_period, a_attr, a_timeout);
        end
        release_a();
    endtask

    initial begin
        test_reset();
        test_hold();
        test_toggle();
        test_timeout();
        test_counter();
        test_back_to_back();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
